sd_spi_engine: RTL
==================

SD_SPI_ENGINE -- requirements
Module: sd_spi_engine

Interface
REQ-001 Parameter DEBOUNCE_BITS, default 16, width of the card-detect stability counter (used only with SD_SPI_CD_DEBOUNCE_EN).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk28 in 1: single system clock.
- rst_n in 1: reset, asynchronous, active-low.
- ck7 in 1: one-clk28-cycle enable strobe, once per 4 clk28 cycles.
- wr_stb in 1: one-cycle strobe, write d_in for transmit.
- rd_stb in 1: one-cycle strobe, read request.
- d_in in 8: write data.
- cs_wr_stb in 1: one-cycle strobe, chip-select update.
- cs_d in 1: new chip-select level.
- d_out out 8: last received byte.
- busy out 1: transfer active or buffer non-empty.
- overrun out 1: sticky, write dropped.
- sd_sck out 1: SPI clock.
- sd_mosi out 1: SPI data out.
- sd_miso in 1: SPI data in.
- sd_cs out 1: card select, active-low.
- sd_cd_raw in 1: raw card-detect pin, 1 = no card.
- sd_cd out 1: conditioned card-detect.

Function
REQ-003 The block SHALL run SPI mode 0, MSB first; sd_sck idles low; sd_mosi idles 1.
REQ-004 States SHALL be IDLE and SHIFT; one SCK half-period SHALL equal one ck7 strobe, giving 16 ck7 strobes per byte.
REQ-005 wr_stb in IDLE SHALL load d_in into the shift register, enter SHIFT, set busy on the next clk28, and drive bit 7 on sd_mosi before the first SCK rise.
REQ-006 rd_stb in IDLE SHALL start a transfer of 0xFF. d_out SHALL NOT change on the read itself: it returns the previous exchange's result.
REQ-007 In SHIFT, each odd ck7 strobe SHALL raise sd_sck and sample sd_miso; each even ck7 strobe SHALL lower sd_sck and shift out the next bit.
REQ-008 On the 16th ck7 strobe the received byte SHALL be written to d_out in the same clk28 cycle.
REQ-009 wr_stb in SHIFT with the one-byte holding buffer empty SHALL store d_in in the buffer.
REQ-010 When a byte completes with the buffer full, the buffer SHALL load into the shift register on the same ck7 strobe and SHIFT SHALL continue with no idle SCK period.
REQ-011 wr_stb while the buffer is full SHALL drop the data and set overrun. overrun SHALL clear only on cs_wr_stb or reset.
REQ-012 rd_stb in SHIFT SHALL be ignored and SHALL NOT be buffered.
REQ-013 If wr_stb and rd_stb occur in the same cycle, wr_stb SHALL take priority and rd_stb SHALL be ignored.
REQ-014 cs_wr_stb SHALL update sd_cs on the next clk28 when busy=0.
REQ-015 If busy=1, the cs update SHALL be held pending and applied in the cycle busy falls. A later cs_wr_stb SHALL overwrite the pending value.
REQ-016 busy SHALL fall one clk28 after the last byte completes with the buffer empty. The block SHALL then be in IDLE with sd_sck=0 and sd_mosi=1.
REQ-017 ck7 strobes in IDLE SHALL have no effect.

Reset
REQ-018 With rst_n low the block SHALL set: IDLE state, d_out=0xFF, busy=0, overrun=0, sd_sck=0, sd_mosi=1, sd_cs=1, sd_cd=1, buffer empty, no pending cs update.
REQ-019 Reset during SHIFT SHALL abort the transfer immediately with no partial d_out update.

Configuration
REQ-020 sd_cd_raw SHALL always pass through a 2-flop synchronizer.
REQ-021 With SD_SPI_CD_DEBOUNCE_EN defined, sd_cd SHALL change only after the synchronized input differs from sd_cd for 2^DEBOUNCE_BITS consecutive clk28 cycles; any glitch SHALL restart the count.
REQ-022 Without SD_SPI_CD_DEBOUNCE_EN, sd_cd SHALL equal the synchronizer output, i.e. sd_cd_raw delayed 2 clk28.

Verification
REQ-023 Scenario: wr_stb d_in=0xA5, sd_miso looped to sd_mosi -> 8 SCK pulses, MOSI 1,0,1,0,0,1,0,1, d_out=0xA5 after 16 ck7 strobes, busy low 1 clk28 later.
REQ-024 Scenario: sd_miso tied 0, rd_stb -> MOSI all 1, d_out=0x00; a second rd_stb returns 0x00 and starts a new exchange.
REQ-025 Scenario: wr 0x12, then 0x34 mid-byte, then 0x56 mid-byte -> 16 contiguous SCK pulses (0x12 then 0x34), 0x56 dropped, overrun=1; cs_wr_stb clears overrun.
REQ-026 Scenario: cs_wr_stb cs_d=0 while busy -> sd_cs stays 1 until busy falls, then 0 in that cycle.
REQ-027 Scenario: assert rst_n low after 5 SCK pulses -> all outputs at reset values immediately; d_out=0xFF.
REQ-028 Scenario: with SD_SPI_CD_DEBOUNCE_EN and DEBOUNCE_BITS=4, a 10-cycle low pulse on sd_cd_raw -> sd_cd stays 1; a 20-cycle low -> sd_cd=0 at 2+16 cycles.

Source files
------------

// File: rtl/sd_spi_engine.sv
// sd_spi_engine: byte-wide SPI mode-0 master (MSB first) for an SD card.
// One SCK half-period lasts one ck7 strobe, so a byte takes 16 strobes.
// A one-byte holding buffer lets back-to-back writes stream without an idle SCK gap.
// Chip-select writes issued while busy are deferred until the transfer drains.
// Optional build macro: SD_SPI_CD_DEBOUNCE_EN adds a stability counter on card-detect.
module sd_spi_engine #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ck7,
    input  logic       wr_stb,
    input  logic       rd_stb,
    input  logic [7:0] d_in,
    input  logic       cs_wr_stb,
    input  logic       cs_d,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       overrun,
    output logic       sd_sck,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       sd_cs,
    input  logic       sd_cd_raw,
    output logic       sd_cd
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] sh_r, sh_s;
    logic [7:0] rx_r, rx_s;
    logic [7:0] buf_r, buf_s;
    logic       buf_full_r, buf_full_s;
    logic [3:0] cnt_r, cnt_s;
    logic [7:0] d_out_r, d_out_s;
    logic       overrun_r, overrun_s;
    logic       sck_r, sck_s;
    logic       mosi_r, mosi_s;
    logic       busy_r, busy_s;
    logic       cs_r, cs_s;
    logic       pend_r, pend_s;
    logic       pend_val_r, pend_val_s;
    logic       byte_end_s;
    logic       cd_meta_r, cd_sync_r;

    // The 16th strobe of a byte: receive complete, decide continue or stop.
    assign byte_end_s = (state_r == ST_SHIFT) && ck7 && (cnt_r == 4'd15);

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sh_r       <= 8'hFF;
            rx_r       <= 8'hFF;
            buf_r      <= 8'h00;
            buf_full_r <= 1'b0;
            cnt_r      <= 4'd0;
            d_out_r    <= 8'hFF;
            overrun_r  <= 1'b0;
            sck_r      <= 1'b0;
            mosi_r     <= 1'b1;
            busy_r     <= 1'b0;
            cs_r       <= 1'b1;
            pend_r     <= 1'b0;
            pend_val_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            sh_r       <= sh_s;
            rx_r       <= rx_s;
            buf_r      <= buf_s;
            buf_full_r <= buf_full_s;
            cnt_r      <= cnt_s;
            d_out_r    <= d_out_s;
            overrun_r  <= overrun_s;
            sck_r      <= sck_s;
            mosi_r     <= mosi_s;
            busy_r     <= busy_s;
            cs_r       <= cs_s;
            pend_r     <= pend_s;
            pend_val_r <= pend_val_s;
        end
    end

    // Next-state, shift/sample, holding buffer and deferred chip-select logic.
    always_comb begin
        state_s    = state_r;
        sh_s       = sh_r;
        rx_s       = rx_r;
        buf_s      = buf_r;
        buf_full_s = buf_full_r;
        cnt_s      = cnt_r;
        d_out_s    = d_out_r;
        sck_s      = sck_r;
        mosi_s     = mosi_r;
        cs_s       = cs_r;
        pend_s     = pend_r;
        pend_val_s = pend_val_r;

        // A chip-select write acknowledges overrun; a same-cycle drop re-sets it below.
        if (cs_wr_stb) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (wr_stb) begin
                    state_s = ST_SHIFT;
                    sh_s    = d_in;
                    mosi_s  = d_in[7];
                    cnt_s   = 4'd0;
                end else if (rd_stb) begin
                    state_s = ST_SHIFT;
                    sh_s    = 8'hFF;
                    mosi_s  = 1'b1;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ck7) begin
                    cnt_s = cnt_r + 4'd1;
                    if (!cnt_r[0]) begin
                        // Rising SCK: sample the card's bit.
                        sck_s = 1'b1;
                        rx_s  = {rx_r[6:0], sd_miso};
                    end else if (cnt_r != 4'd15) begin
                        // Falling SCK: present the next bit.
                        sck_s  = 1'b0;
                        sh_s   = {sh_r[6:0], 1'b0};
                        mosi_s = sh_r[6];
                    end else begin
                        sck_s   = 1'b0;
                        d_out_s = rx_r;
                        if (buf_full_r) begin
                            sh_s       = buf_r;
                            mosi_s     = buf_r[7];
                            buf_full_s = 1'b0;
                        end else if (wr_stb) begin
                            // Write landing on the closing strobe goes straight to the shifter.
                            sh_s   = d_in;
                            mosi_s = d_in[7];
                        end else begin
                            state_s = ST_IDLE;
                            mosi_s  = 1'b1;
                        end
                    end
                end else begin
                    cnt_s = cnt_r;
                end
                if (wr_stb) begin
                    if (byte_end_s) begin
                        if (buf_full_r) begin
                            buf_s      = d_in;
                            buf_full_s = 1'b1;
                        end else begin
                            buf_s = buf_r;
                        end
                    end else if (!buf_full_r) begin
                        buf_s      = d_in;
                        buf_full_s = 1'b1;
                    end else begin
                        overrun_s = 1'b1;
                    end
                end else begin
                    buf_s = buf_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // busy covers the transfer plus the single cycle after it ends.
        busy_s = (state_r == ST_SHIFT) || (state_s == ST_SHIFT);

        if (!busy_r) begin
            if (cs_wr_stb) begin
                cs_s = cs_d;
            end else begin
                cs_s = cs_r;
            end
            pend_s = 1'b0;
        end else if (!busy_s) begin
            // busy falls now: apply the newest requested level.
            if (cs_wr_stb) begin
                cs_s = cs_d;
            end else if (pend_r) begin
                cs_s = pend_val_r;
            end else begin
                cs_s = cs_r;
            end
            pend_s = 1'b0;
        end else begin
            if (cs_wr_stb) begin
                pend_s     = 1'b1;
                pend_val_s = cs_d;
            end else begin
                pend_s     = pend_r;
                pend_val_s = pend_val_r;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous card-detect pin.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cd_meta_r <= 1'b1;
            cd_sync_r <= 1'b1;
        end else begin
            cd_meta_r <= sd_cd_raw;
            cd_sync_r <= cd_meta_r;
        end
    end

`ifdef SD_SPI_CD_DEBOUNCE_EN
    logic [DEBOUNCE_BITS-1:0] db_cnt_r;
    logic                     cd_r;

    // Accept a new card-detect level only after 2^DEBOUNCE_BITS stable cycles.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= '0;
            cd_r     <= 1'b1;
        end else if (cd_sync_r != cd_r) begin
            if (&db_cnt_r) begin
                db_cnt_r <= '0;
                cd_r     <= cd_sync_r;
            end else begin
                db_cnt_r <= db_cnt_r + DEBOUNCE_BITS'(1);
            end
        end else begin
            db_cnt_r <= '0;
        end
    end

    assign sd_cd = cd_r;
`else
    // No debounce counter in this build; the width parameter stays for interface compatibility.
    logic [DEBOUNCE_BITS-1:0] cd_db_unused_s;
    assign cd_db_unused_s = '0;
    assign sd_cd          = cd_sync_r;
`endif

    assign d_out   = d_out_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;
    assign sd_sck  = sck_r;
    assign sd_mosi = mosi_r;
    assign sd_cs   = cs_r;

endmodule
